// File: rtl/map_pkg.sv
// Shared types, block ids, opcodes and helpers for the map write-side master.
package map_pkg;

    localparam int AXIS_BITS = 5;
    localparam int ADDR_BITS = 3 * AXIS_BITS;
    localparam int ID_BITS   = 5;

    typedef logic [AXIS_BITS-1:0] axis_t;
    typedef logic [ADDR_BITS-1:0] addr_t;
    typedef logic [ID_BITS-1:0]   block_id_t;

    localparam block_id_t AIR     = 5'd0;
    localparam block_id_t GRASS   = 5'd1;
    localparam block_id_t DIRT    = 5'd2;
    localparam block_id_t STONE   = 5'd3;
    localparam block_id_t BEDROCK = 5'd4;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_PLACE = 2'd1,
        OP_BREAK = 2'd2,
        OP_FILL  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FILL  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Field order makes the packed struct identical to the {y,z,x} map address.
    typedef struct packed {
        axis_t y;
        axis_t z;
        axis_t x;
    } xyz_t;

    function automatic addr_t pack_addr(input xyz_t p);
        return {p.y, p.z, p.x};
    endfunction

    function automatic block_id_t terrain_id(input axis_t y, input int ground_h,
                                             input int dirt_depth);
        int yi;
        yi = int'(y);
        if (yi == 0)                          return BEDROCK;
        else if (yi < ground_h - dirt_depth)  return STONE;
        else if (yi < ground_h)               return DIRT;
        else if (yi == ground_h)              return GRASS;
        else                                  return AIR;
    endfunction

endpackage

// File: rtl/map_writer_if.sv
// Edit-command valid/ready bus into map_writer.
interface map_writer_if;

    logic              cmd_valid;
    logic              cmd_ready;
    map_pkg::op_e      cmd_op;
    map_pkg::axis_t    cmd_x0;
    map_pkg::axis_t    cmd_y0;
    map_pkg::axis_t    cmd_z0;
    map_pkg::axis_t    cmd_x1;
    map_pkg::axis_t    cmd_y1;
    map_pkg::axis_t    cmd_z1;
    map_pkg::block_id_t cmd_id;

    modport master (
        output cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_z0,
               cmd_x1, cmd_y1, cmd_z1, cmd_id,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_z0,
               cmd_x1, cmd_y1, cmd_z1, cmd_id,
        output cmd_ready
    );

endinterface

// File: rtl/map_xyz_counter.sv
// Three-axis bounded counter, x innermost then z then y; cur/last are valid in
// the load cycle so the first cell can be written without a bubble.
module map_xyz_counter
    import map_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  xyz_t lo_in,
    input  xyz_t hi_in,
    input  logic step,
    output xyz_t cur,
    output logic last
);

    xyz_t lo_q, lo_d;
    xyz_t hi_q, hi_d;
    xyz_t pos_q, pos_d;

    // NOTE: every variable gets a default at the top of the block, so no path
    // through the ifs can leave one unassigned and infer a latch.
    always_comb begin
        lo_d  = load ? lo_in : lo_q;
        hi_d  = load ? hi_in : hi_q;
        cur   = load ? lo_in : pos_q;
        last  = (cur == hi_d);
        pos_d = cur;
        if (step) begin
            if (cur.x != hi_d.x) begin
                pos_d.x = cur.x + 1'b1;
            end else begin
                pos_d.x = lo_d.x;
                if (cur.z != hi_d.z) begin
                    pos_d.z = cur.z + 1'b1;
                end else begin
                    pos_d.z = lo_d.z;
                    pos_d.y = (cur.y != hi_d.y) ? cur.y + 1'b1 : lo_d.y;
                end
            end
        end
    end

    // Reset range is the whole world, which is exactly what the INIT sweep needs.
    // NOTE: sequential state uses non-blocking assignments so all flops update
    // together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q  <= '0;
            hi_q  <= '1;
            pos_q <= '0;
        end else begin
            lo_q  <= lo_d;
            hi_q  <= hi_d;
            pos_q <= pos_d;
        end
    end

endmodule

// File: rtl/map_writer.sv
// Write-side master for the map RAM: terrain sweep after reset, then PLACE/BREAK/FILL.
// Optional MAP_WRITER_PROTECT_EN suppresses command writes to the bedrock layer (y==0).
module map_writer
    import map_pkg::*;
#(
    parameter int GROUND_H   = 8,
    parameter int DIRT_DEPTH = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    map_writer_if.slave  cmd,
    output addr_t        write_addr,
    output block_id_t    write_data,
    output logic         write_en,
    output logic         init_done,
    output logic         busy
);

    state_e    state_q, state_d;
    logic      write_en_q, write_en_d;
    addr_t     write_addr_q, write_addr_d;
    block_id_t write_data_q, write_data_d;
    logic      init_done_q, init_done_d;
    logic      busy_q, busy_d;
    block_id_t fill_id_q, fill_id_d;

    logic      cnt_load, cnt_step, cnt_last;
    xyz_t      cnt_cur, fill_lo, fill_hi;
    logic      accept, cmd_wr;
    xyz_t      wr_pos;
    block_id_t wr_id;

    // NOTE: cmd_ready is a pure decode of the state register, never of cmd_valid,
    // so the handshake cannot form a combinational loop with the source.
    assign cmd.cmd_ready = (state_q == ST_IDLE);
    assign accept        = cmd.cmd_valid && (state_q == ST_IDLE);

    always_comb begin
        fill_lo.x = (cmd.cmd_x0 < cmd.cmd_x1) ? cmd.cmd_x0 : cmd.cmd_x1;
        fill_hi.x = (cmd.cmd_x0 < cmd.cmd_x1) ? cmd.cmd_x1 : cmd.cmd_x0;
        fill_lo.y = (cmd.cmd_y0 < cmd.cmd_y1) ? cmd.cmd_y0 : cmd.cmd_y1;
        fill_hi.y = (cmd.cmd_y0 < cmd.cmd_y1) ? cmd.cmd_y1 : cmd.cmd_y0;
        fill_lo.z = (cmd.cmd_z0 < cmd.cmd_z1) ? cmd.cmd_z0 : cmd.cmd_z1;
        fill_hi.z = (cmd.cmd_z0 < cmd.cmd_z1) ? cmd.cmd_z1 : cmd.cmd_z0;
    end

    map_xyz_counter u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cnt_load),
        .lo_in (fill_lo),
        .hi_in (fill_hi),
        .step  (cnt_step),
        .cur   (cnt_cur),
        .last  (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_INIT;
        else        state_q <= state_d;
    end

    // DRAIN is the cycle after the final write of a sweep or command.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  if (cnt_last) state_d = ST_DRAIN;
            ST_IDLE: begin
                if (accept) begin
                    case (cmd.cmd_op)
                        OP_PLACE, OP_BREAK: state_d = ST_DRAIN;
                        OP_FILL:            state_d = cnt_last ? ST_DRAIN : ST_FILL;
                        default:            state_d = ST_IDLE;
                    endcase
                end
            end
            ST_FILL:  if (cnt_last) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_INIT;
        endcase
    end

    always_comb begin
        cnt_load     = 1'b0;
        cnt_step     = 1'b0;
        cmd_wr       = 1'b0;
        wr_pos       = cnt_cur;
        wr_id        = fill_id_q;
        fill_id_d    = fill_id_q;
        write_en_d   = 1'b0;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        case (state_q)
            ST_INIT: begin
                cnt_step     = 1'b1;
                write_en_d   = 1'b1;
                write_addr_d = pack_addr(cnt_cur);
                write_data_d = terrain_id(cnt_cur.y, GROUND_H, DIRT_DEPTH);
            end
            ST_IDLE: begin
                if (accept) begin
                    case (cmd.cmd_op)
                        OP_PLACE: begin
                            cmd_wr = 1'b1;
                            wr_pos = '{y: cmd.cmd_y0, z: cmd.cmd_z0, x: cmd.cmd_x0};
                            wr_id  = cmd.cmd_id;
                        end
                        OP_BREAK: begin
                            cmd_wr = 1'b1;
                            wr_pos = '{y: cmd.cmd_y0, z: cmd.cmd_z0, x: cmd.cmd_x0};
                            wr_id  = AIR;
                        end
                        OP_FILL: begin
                            cnt_load  = 1'b1;
                            cnt_step  = 1'b1;
                            cmd_wr    = 1'b1;
                            wr_id     = cmd.cmd_id;
                            fill_id_d = cmd.cmd_id;
                        end
                        default: ;
                    endcase
                end
            end
            ST_FILL: begin
                cnt_step = 1'b1;
                cmd_wr   = 1'b1;
            end
            default: ;
        endcase
        if (cmd_wr) begin
            write_addr_d = pack_addr(wr_pos);
            write_data_d = wr_id;
`ifdef MAP_WRITER_PROTECT_EN
            write_en_d   = (wr_pos.y != '0);
`else
            write_en_d   = 1'b1;
`endif
        end
        init_done_d = init_done_q || (state_q == ST_DRAIN);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            init_done_q  <= 1'b0;
            busy_q       <= 1'b1;
            fill_id_q    <= '0;
        end else begin
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            init_done_q  <= init_done_d;
            busy_q       <= busy_d;
            fill_id_q    <= fill_id_d;
        end
    end

    assign write_en   = write_en_q;
    assign write_addr = write_addr_q;
    assign write_data = write_data_q;
    assign init_done  = init_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_map_writer.sv
// Directed bench for map_writer: terrain sweep, PLACE/BREAK/FILL/NOP, reset mid-FILL.
module tb_map_writer;
    import map_pkg::*;

    logic      clk;
    logic      rst_n;
    addr_t     write_addr;
    block_id_t write_data;
    logic      write_en;
    logic      init_done;
    logic      busy;

    int n_cmp = 0;
    int n_err = 0;

    int fill_exp [4] = '{10401, 10402, 10433, 10434};

    map_writer_if cmd_if ();

    map_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cmd_if),
        .write_addr (write_addr),
        .write_data (write_data),
        .write_en   (write_en),
        .init_done  (init_done),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // GROUND_H=8, DIRT_DEPTH=3: y0 bedrock, y1..4 stone, y5..7 dirt, y8 grass, above air.
    function automatic int terrain_model(input int y);
        if (y == 0)      return 4;
        else if (y <= 4) return 3;
        else if (y <= 7) return 2;
        else if (y == 8) return 1;
        else             return 0;
    endfunction

    // Called on a negedge; returns on the negedge right after the accepting posedge.
    task automatic send_cmd(input op_e op, input axis_t x0, input axis_t y0, input axis_t z0,
                            input axis_t x1, input axis_t y1, input axis_t z1,
                            input block_id_t id);
        int waited = 0;
        while (!cmd_if.cmd_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("ready_before_cmd", cmd_if.cmd_ready, 1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_x0    = x0;
        cmd_if.cmd_y0    = y0;
        cmd_if.cmd_z0    = z0;
        cmd_if.cmd_x1    = x1;
        cmd_if.cmd_y1    = y1;
        cmd_if.cmd_z1    = z1;
        cmd_if.cmd_id    = id;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
    endtask

    initial begin
        int k;
        int bad_order;
        int bad_flags;
        int n_wr;
        int exp_wr;

        rst_n            = 1'b0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_PLACE;
        cmd_if.cmd_x0    = 5'd3;
        cmd_if.cmd_y0    = 5'd9;
        cmd_if.cmd_z0    = 5'd4;
        cmd_if.cmd_x1    = 5'd0;
        cmd_if.cmd_y1    = 5'd0;
        cmd_if.cmd_z1    = 5'd0;
        cmd_if.cmd_id    = 5'd5;

        @(negedge clk);
        check("rst_write_en", write_en, 0);
        check("rst_write_addr", write_addr, 0);
        check("rst_write_data", write_data, 0);
        check("rst_init_done", init_done, 0);
        check("rst_busy", busy, 1);
        check("rst_cmd_ready", cmd_if.cmd_ready, 0);

        // Sweep with a PLACE held valid the whole time.
        rst_n = 1'b1;
        @(negedge clk);
        k = 0;
        bad_order = 0;
        bad_flags = 0;
        while (!cmd_if.cmd_ready && k < 33000) begin
            if (!write_en || write_addr != 15'(k) || write_data != 5'(terrain_model(k >> 10)))
                bad_order++;
            if (init_done || !busy) bad_flags++;
            if (k == 0)    check("sweep_a0_bedrock", write_data, 4);
            if (k == 1024) check("sweep_a1024_stone", write_data, 3);
            if (k == 5120) check("sweep_a5120_dirt", write_data, 2);
            if (k == 8192) check("sweep_a8192_grass", write_data, 1);
            if (k == 9216) check("sweep_a9216_air", write_data, 0);
            k++;
            @(negedge clk);
        end
        check("sweep_cycles", k, 32768);
        check("sweep_order_bad", bad_order, 0);
        check("sweep_flags_bad", bad_flags, 0);
        check("sweep_end_write_en", write_en, 0);
        check("sweep_end_init_done", init_done, 1);
        check("sweep_end_busy", busy, 0);

        // First IDLE cycle: the held PLACE is accepted on the coming edge.
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        check("place_write_en", write_en, 1);
        check("place_addr", write_addr, 9347);
        check("place_data", write_data, 5);
        check("place_ready_low", cmd_if.cmd_ready, 0);
        check("place_busy", busy, 1);
        @(negedge clk);
        check("place_after_write_en", write_en, 0);
        check("place_ready_back", cmd_if.cmd_ready, 1);
        check("place_busy_back", busy, 0);

        // FILL with reversed z corners.
        send_cmd(OP_FILL, 5'd1, 5'd10, 5'd6, 5'd2, 5'd10, 5'd5, 5'd3);
        for (int i = 0; i < 4; i++) begin
            check("fill4_write_en", write_en, 1);
            check("fill4_addr", write_addr, fill_exp[i]);
            check("fill4_data", write_data, 3);
            check("fill4_ready_low", cmd_if.cmd_ready, 0);
            @(negedge clk);
        end
        check("fill4_end_write_en", write_en, 0);
        check("fill4_ready_back", cmd_if.cmd_ready, 1);

        send_cmd(OP_BREAK, 5'd7, 5'd0, 5'd7, 5'd0, 5'd0, 5'd0, 5'd9);
`ifdef MAP_WRITER_PROTECT_EN
        check("break_y0_suppressed", write_en, 0);
`else
        check("break_write_en", write_en, 1);
        check("break_addr", write_addr, 231);
        check("break_data", write_data, 0);
`endif
        check("break_ready_low", cmd_if.cmd_ready, 0);
        @(negedge clk);
        check("break_ready_back", cmd_if.cmd_ready, 1);
        check("break_end_write_en", write_en, 0);

        send_cmd(OP_NOP, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1);
        check("nop_write_en", write_en, 0);
        check("nop_ready", cmd_if.cmd_ready, 1);
        check("nop_busy", busy, 0);

        // Whole-world FILL with fully reversed corners.
        send_cmd(OP_FILL, 5'd31, 5'd31, 5'd31, 5'd0, 5'd0, 5'd0, 5'd7);
        k = 0;
        n_wr = 0;
        bad_order = 0;
        while (!cmd_if.cmd_ready && k < 33000) begin
            if (write_en) begin
                n_wr++;
                if (write_addr != 15'(k) || write_data != 5'd7) bad_order++;
            end
            k++;
            @(negedge clk);
        end
`ifdef MAP_WRITER_PROTECT_EN
        exp_wr = 31744;
`else
        exp_wr = 32768;
`endif
        check("fillall_cycles", k, 32768);
        check("fillall_writes", n_wr, exp_wr);
        check("fillall_order_bad", bad_order, 0);
        check("fillall_end_write_en", write_en, 0);

        // Reset asserted between edges in the middle of a FILL.
        send_cmd(OP_FILL, 5'd0, 5'd1, 5'd0, 5'd31, 5'd5, 5'd31, 5'd6);
        @(negedge clk);
        @(negedge clk);
        check("midfill_write_en", write_en, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_write_en", write_en, 0);
        check("async_rst_init_done", init_done, 0);
        check("async_rst_ready", cmd_if.cmd_ready, 0);
        check("async_rst_busy", busy, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("resweep_write_en", write_en, 1);
        check("resweep_addr0", write_addr, 0);
        check("resweep_data0", write_data, 4);
        check("resweep_init_done", init_done, 0);
        @(negedge clk);
        check("resweep_addr1", write_addr, 1);
        check("resweep_ready", cmd_if.cmd_ready, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
